// File: rtl/fft_input_loader_if.sv
// Stream-in, RAM-write and engine-control signals of the FFT input loader.
// The master modport is the loader. The slave modport is the environment that feeds it.
interface fft_input_loader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                    enable;
    logic                    s_valid;
    logic                    s_ready;
    logic [DATA_WIDTH-1:0]   s_data;
    logic                    ram_wen;
    logic [ADDR_WIDTH-1:0]   ram_waddr;
    logic [2*DATA_WIDTH-1:0] ram_wdata;
    logic                    start;
    logic                    fft_done;
    logic                    busy;
    logic [15:0]             frame_cnt;

    modport master (
        input  enable, s_valid, s_data, fft_done,
        output s_ready, ram_wen, ram_waddr, ram_wdata, start, busy, frame_cnt
    );

    modport slave (
        output enable, s_valid, s_data, fft_done,
        input  s_ready, ram_wen, ram_waddr, ram_wdata, start, busy, frame_cnt
    );
endinterface

// File: rtl/fft_input_loader.sv
// Loads one frame of real samples into the FFT RAM in bit-reversed order with zero imaginary part.
// It then launches the FFT engine and waits for it to finish before accepting another frame.
module fft_input_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int IN_SHIFT   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    fft_input_loader_if.master  bus
);
    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, START, WAIT_FFT} state_t;

    state_t                  r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_cnt, w_cnt_nxt;
    logic                    r_wen, w_wen_nxt;
    logic [ADDR_WIDTH-1:0]   r_waddr, w_waddr_nxt;
    logic [2*DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
    logic                    r_start, w_start_nxt;
    logic                    r_busy, w_busy_nxt;
    logic [15:0]             r_frames, w_frames_nxt;

    logic                    w_hs;
    logic signed [DATA_WIDTH-1:0] w_shifted;

    function automatic logic [ADDR_WIDTH-1:0] bitrev(input logic [ADDR_WIDTH-1:0] i);
        logic [ADDR_WIDTH-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < ADDR_WIDTH; k++) begin
            r[k] = i[ADDR_WIDTH-1-k];
        end
        return r;
    endfunction

    assign w_hs      = bus.s_valid && (r_state == LOAD);
    assign w_shifted = $signed(bus.s_data) >>> IN_SHIFT;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_wen_nxt    = 1'b0;
        w_waddr_nxt  = r_waddr;
        w_wdata_nxt  = r_wdata;
        w_start_nxt  = 1'b0;
        w_busy_nxt   = r_busy;
        w_frames_nxt = r_frames;
        case (r_state)
            IDLE: begin
                if (bus.enable) begin
                    w_state_nxt = LOAD;
                    w_busy_nxt  = 1'b1;
                end
            end
            LOAD: begin
                if (w_hs) begin
                    w_wen_nxt   = 1'b1;
                    w_waddr_nxt = bitrev(r_cnt);
                    w_wdata_nxt = {{DATA_WIDTH{1'b0}}, w_shifted};
                    // The counter holds at N-1 on the final sample, so it never leaves the frame range.
                    if (&r_cnt) w_state_nxt = FLUSH;
                    else        w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            FLUSH: begin
                w_state_nxt = START;
                w_start_nxt = 1'b1;
            end
            START: begin
                w_cnt_nxt   = '0;
                w_state_nxt = WAIT_FFT;
            end
            WAIT_FFT: begin
                if (bus.fft_done) begin
                    w_frames_nxt = r_frames + 16'd1;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_wen    <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_start  <= 1'b0;
            r_busy   <= 1'b0;
            r_frames <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_wen    <= w_wen_nxt;
            r_waddr  <= w_waddr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_start  <= w_start_nxt;
            r_busy   <= w_busy_nxt;
            r_frames <= w_frames_nxt;
        end
    end

    assign bus.s_ready   = (r_state == LOAD);
    assign bus.ram_wen   = r_wen;
    assign bus.ram_waddr = r_waddr;
    assign bus.ram_wdata = r_wdata;
    assign bus.start     = r_start;
    assign bus.busy      = r_busy;
    assign bus.frame_cnt = r_frames;
endmodule
